// File: rtl/intc8.sv
// Eight-source edge-triggered interrupt controller with fixed priority
// (bit 0 highest), a 4-register slave port and an ack/iret handshake to the CPU.
module intc8 #(
  parameter int N_SRC = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [1:0]       i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  output logic             o_rdy,
  input  logic [N_SRC-1:0] i_irq,
  output logic             o_int,
  output logic [2:0]       o_vec,
  input  logic             i_int_ack,
  input  logic             i_iret
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state;
  logic [7:0] enable, pending, irq_q, irq8, rise, clr, cand;
  logic       gen;
  logic [2:0] winner;
  logic       wr;

  // Widen the request lines so sources at or above N_SRC read as constant 0.
  always_comb begin
    irq8 = '0;
    irq8[N_SRC-1:0] = i_irq;
  end

  assign wr   = i_sel & i_we;
  assign rise = irq8 & ~irq_q;
  assign cand = pending & enable;

  always_comb begin
    clr = '0;
    if (wr && i_addr == 2'd1) clr = i_wdata[7:0];
    if (state == REQ && i_int_ack) clr[o_vec] = 1'b1;
  end

  always_comb begin
    winner = '0;
    for (int i = 7; i >= 0; i--)
      if (cand[i]) winner = 3'(i);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_q   <= '0;
      pending <= '0;
      enable  <= '0;
      gen     <= 1'b0;
    end else begin
      irq_q   <= irq8;
      // A rise in the same cycle as a clear keeps the bit set.
      pending <= ((pending & ~clr) | rise) & SRC_MASK;
      if (wr && i_addr == 2'd0) enable <= i_wdata[7:0] & SRC_MASK;
      if (wr && i_addr == 2'd2) gen <= i_wdata[0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_int <= 1'b0;
      o_vec <= '0;
    end else begin
      case (state)
        IDLE: if (gen && cand != '0) begin
          state <= REQ;
          o_vec <= winner;
          o_int <= 1'b1;
        end
        REQ: if (i_int_ack) begin
          state <= SERVICE;
          o_int <= 1'b0;
        end else if (!gen || !enable[o_vec] || !pending[o_vec]) begin
          // Request withdrawn before the CPU took it; pending is left alone.
          state <= IDLE;
          o_int <= 1'b0;
        end
        SERVICE: if (i_iret) state <= IDLE;
        default: begin
          state <= IDLE;
          o_int <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_sel && i_re) begin
      case (i_addr)
        2'd0: o_rdata = {8'b0, enable};
        2'd1: o_rdata = {8'b0, pending};
        2'd2: o_rdata = {15'b0, gen};
        2'd3: o_rdata = {11'b0, state == SERVICE, state == REQ, o_vec};
        default: o_rdata = '0;
      endcase
    end
  end

  assign o_rdy = i_sel;

endmodule

// File: tb/tb_intc8.sv
// Directed bench for intc8: priority, handshake, withdraw, W1C races, async reset.
module tb_intc8;

  logic        i_clk = 0, i_rst = 1;
  logic        i_sel = 0, i_we = 0, i_re = 0;
  logic [1:0]  i_addr = 0;
  logic [15:0] i_wdata = 0, o_rdata;
  logic        o_rdy, o_int, i_int_ack = 0, i_iret = 0;
  logic [7:0]  i_irq = 0;
  logic [2:0]  o_vec;
  int          total = 0, bad = 0;
  logic [15:0] d;

  intc8 #(.N_SRC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy),
    .i_irq(i_irq), .o_int(o_int), .o_vec(o_vec),
    .i_int_ack(i_int_ack), .i_iret(i_iret)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] v);
    i_sel = 1; i_we = 1; i_addr = a; i_wdata = v;
    tick();
    i_sel = 0; i_we = 0; i_wdata = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    i_sel = 1; i_re = 1; i_addr = a;
    #1 v = o_rdata;
    i_sel = 0; i_re = 0;
  endtask

  task automatic ack();
    i_int_ack = 1; tick(); i_int_ack = 0;
  endtask

  task automatic iret();
    i_iret = 1; tick(); i_iret = 0;
  endtask

  initial begin
    tick(); tick();
    i_rst = 0;
    tick();
    chk("rst_int", 16'(o_int), 16'h0);
    chk("rst_vec", 16'(o_vec), 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d); chk("rst_reg", d, 16'h0);
    end
    i_sel = 1; #1 chk("rdy", 16'(o_rdy), 16'h1);
    chk("rdata_no_re", o_rdata, 16'h0);
    i_sel = 0;

    // timer source, single request
    wr(0, 16'h01); wr(2, 16'h1);
    i_irq = 8'h01; tick();
    chk("t1_lat1", 16'(o_int), 16'h0);
    rd(1, d); chk("t1_pend", d, 16'h0001);
    tick();
    chk("t1_int", 16'(o_int), 16'h1);
    chk("t1_vec", 16'(o_vec), 16'h0);
    rd(3, d); chk("t1_st_req", d, 16'h0008);
    ack();
    chk("t1_ack_int", 16'(o_int), 16'h0);
    rd(1, d); chk("t1_ack_pend", d, 16'h0000);
    rd(3, d); chk("t1_st_svc", d, 16'h0010);
    iret();
    rd(3, d); chk("t1_st_idle", d, 16'h0000);
    tick(); tick(); tick();
    chk("t1_no_retrig", 16'(o_int), 16'h0);
    i_irq = 0; tick();

    // simultaneous rise: 2 beats 5
    wr(0, 16'hFF);
    i_irq = 8'h24; tick(); tick();
    chk("t2_int", 16'(o_int), 16'h1);
    chk("t2_vec2", 16'(o_vec), 16'h2);
    ack();
    rd(1, d); chk("t2_pend", d, 16'h0020);
    rd(3, d); chk("t2_st", d, 16'h0012);
    iret();
    chk("t2_gap", 16'(o_int), 16'h0);
    tick();
    chk("t2_int5", 16'(o_int), 16'h1);
    chk("t2_vec5", 16'(o_vec), 16'h5);
    ack(); iret();
    i_irq = 0; tick();

    // no preemption while in REQ
    i_irq = 8'h08; tick(); tick();
    chk("t3_vec3", 16'(o_vec), 16'h3);
    i_irq = 8'h0A; tick(); tick();
    chk("t3_hold_int", 16'(o_int), 16'h1);
    chk("t3_hold_vec", 16'(o_vec), 16'h3);
    ack();
    rd(1, d); chk("t3_pend", d, 16'h0002);
    iret(); tick();
    chk("t3_int1", 16'(o_int), 16'h1);
    chk("t3_vec1", 16'(o_vec), 16'h1);
    ack(); iret();
    i_irq = 0; tick();

    // withdraw by GEN=0, then re-request
    i_irq = 8'h40; tick(); tick();
    chk("t4_vec6", 16'(o_vec), 16'h6);
    wr(2, 16'h0); tick();
    chk("t4_drop", 16'(o_int), 16'h0);
    rd(1, d); chk("t4_pend", d, 16'h0040);
    wr(2, 16'h1); tick();
    chk("t4_reint", 16'(o_int), 16'h1);
    chk("t4_revec", 16'(o_vec), 16'h6);
    ack(); iret();
    i_irq = 0; tick();

    // W1C racing a new rise
    wr(2, 16'h0);
    i_irq = 8'h04; tick();
    i_irq = 8'h00; tick();
    rd(1, d); chk("t5_pre", d, 16'h0004);
    i_irq = 8'h04; wr(1, 16'h0004);
    rd(1, d); chk("t5_set_wins", d, 16'h0004);
    wr(1, 16'h0004);
    rd(1, d); chk("t5_w1c", d, 16'h0000);

    // async reset in SERVICE
    i_irq = 0; wr(2, 16'h1);
    i_irq = 8'h80; tick(); tick();
    chk("t6_vec7", 16'(o_vec), 16'h7);
    ack();
    rd(3, d); chk("t6_svc", d, 16'h0017);
    i_irq = 0;
    #2 i_rst = 1;
    #1 chk("t6_rst_int", 16'(o_int), 16'h0);
    chk("t6_rst_vec", 16'(o_vec), 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d); chk("t6_rst_reg", d, 16'h0);
    end
    tick();
    i_rst = 0;
    i_iret = 1; i_int_ack = 1; tick();
    i_iret = 0; i_int_ack = 0;
    rd(3, d); chk("t6_spur_st", d, 16'h0000);
    tick();
    chk("t6_spur_int", 16'(o_int), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intc8.md
# intc8

Eight-source interrupt controller that sits directly downstream of the peripheral blocks. Source 0 is the 16-bit timer's interrupt-request output. It turns rising edges on the request lines into pending bits, masks them, and picks the highest-priority one. It then presents a single interrupt request plus a vector to the CPU using an ack/return handshake. Software reaches it through the same 4-word memory-mapped slave bus as the other peripherals.

## Interface
- N_SRC, 8, number of request inputs (1..8); vector width is fixed at 3.
- i_clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_sel  in  1  slave select.
- i_we  in  1  write strobe (valid with i_sel).
- i_re  in  1  read strobe (valid with i_sel).
- i_addr  in  2  register index.
- i_wdata  in  16  write data.
- o_rdata  out  16  read data, combinational; 0 unless i_sel && i_re.
- o_rdy  out  1  equals i_sel (zero-wait-state slave).
- i_irq  in  N_SRC  level request lines from peripherals; bit 0 = timer.
- o_int  out  1  registered interrupt request to CPU.
- o_vec  out  3  registered index of the granted source; valid while o_int or in service.
- i_int_ack  in  1  CPU accepts the request (single-cycle pulse).
- i_iret  in  1  CPU finished the handler (single-cycle pulse).

## Operation
- Register map (i_sel && i_we writes; reads combinational):
  - 0 ENABLE: bits[N_SRC-1:0] per-source mask, R/W.
  - 1 PENDING: read = pending bits; write-1-to-clear.
  - 2 CTRL: bit0 global enable (GEN), R/W.
  - 3 STATUS: read-only, {11'b0, state==SERVICE, state==REQ, o_vec}; writes ignored.
  - Unused upper bits read 0.
- Edge detect:
  - irq_q <= i_irq every cycle.
  - rise = i_irq & ~irq_q.
  - pending[i] <= 1 on rise[i].
- Pending clear sources: W1C write, and ack of source i in REQ.
- Set wins over any clear in the same cycle.
- Candidate set = pending & ENABLE. Winner = lowest set index (bit 0 highest priority).
- FSM states:
  - IDLE:
    - if GEN && candidates != 0: go to REQ, latch o_vec = winner, o_int <= 1.
  - REQ:
    - o_vec is frozen; a newly pending higher-priority source does not preempt.
    - on i_int_ack: clear pending[o_vec], o_int <= 0, go to SERVICE.
    - if GEN==0, or ENABLE[o_vec]==0, or pending[o_vec]==0 (W1C) before ack: o_int <= 0, go to IDLE, pending untouched.
    - Ack takes precedence when ack and withdraw happen in the same cycle.
  - SERVICE:
    - no new request (no nesting); o_vec held.
    - on i_iret: go to IDLE.
    - i_int_ack in SERVICE or IDLE is ignored; i_iret in IDLE or REQ is ignored.
- Source at or above N_SRC: pending/enable bits tie to 0.
- Reset (async, any state): state=IDLE, o_int=0, o_vec=0, pending=0, ENABLE=0, GEN=0, irq_q=0.
  - A line already high when reset releases is treated as a rising edge (irq_q=0).

## Timing
- i_irq[i] high at edge k (low at k-1): pending[i] visible after edge k.
- o_int=1 after edge k+1 when GEN and ENABLE[i] are already set: 2-cycle latency from sampled rise.
- Enabling a source that is already pending: o_int asserts one edge after the enabling write.
- i_int_ack sampled at edge a: o_int=0 and pending[o_vec]=0 after edge a.
- i_iret at edge r: IDLE after r. A remaining candidate raises o_int after edge r+1.
- Back-to-back service: minimum 1 IDLE cycle between SERVICE and the next REQ.
- o_rdata reflects register state of the current cycle, including pending bits set at the previous edge.

## Test plan
- Reset, ENABLE=0x01, GEN=1, pulse i_irq[0] high and hold:
  - o_int=1 two cycles later, o_vec=0.
  - ack -> o_int=0, PENDING=0x00, STATUS=0x0010.
  - iret -> STATUS=0x0000.
  - Held level does not re-trigger.
- i_irq[5] and i_irq[2] rise together, ENABLE=0xFF:
  - o_vec=2 first.
  - After ack+iret, o_vec=5 is granted; PENDING reads 0x20 in between.
- In REQ with o_vec=3, raise i_irq[1]:
  - o_vec stays 3 until ack.
  - Source 1 is granted after iret.
- In REQ, write CTRL=0:
  - o_int drops next edge, PENDING unchanged.
  - Write CTRL=1 -> request reasserts.
- W1C PENDING=0x04 in the same cycle as a new rise on bit 2:
  - PENDING bit 2 stays 1.
- Assert i_rst mid-SERVICE:
  - o_int=0, o_vec=0, all registers read 0 immediately, without waiting for a clock edge.
  - Spurious i_iret and i_int_ack after reset have no effect.
